// File: rtl/cascade_lake_ctrl.sv
// ---------------------------------------------------------------------------
// cascade_lake_ctrl
//
// Stream scheduler for the two-stage cascaded 3x3 stencil pipeline
// (input register -> buf1 -> conv -> buf2 -> output). Accepts one pixel per
// cycle through a valid/ready handshake, drives the shared clock enable of
// both line buffers, and tags which datapath results are real. After the
// last pixel it drains the pipeline and pulses done.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-low reset
//   start       in   one-cycle frame request, honoured only when idle
//   in_valid    in   an input pixel is present
//   in_ready    out  controller accepts the pixel this cycle
//   ub_clk_en   out  clock enable for buf1, buf2 and the input register
//   conv_valid  out  stage-1 (conv) result is valid this cycle
//   out_valid   out  final output pixel is valid this cycle
//   out_last    out  qualifies the last out_valid of the frame
//   busy        out  frame in progress (RUN or DRAIN)
//   done        out  one-cycle pulse at the end of the frame
// ---------------------------------------------------------------------------
module cascade_lake_ctrl #(
  parameter int IMG_W    = 64,
  parameter int IMG_H    = 64,
  parameter int PIPE_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic in_valid,
  output logic in_ready,
  output logic ub_clk_en,
  output logic conv_valid,
  output logic out_valid,
  output logic out_last,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0] X_MAX     = 16'(IMG_W - 1);
  localparam logic [15:0] Y_MAX     = 16'(IMG_H - 1);
  localparam logic [3:0]  DRAIN_MAX = 4'(PIPE_LAT - 1);

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;

  // Flag pipe entry: bit 0 = conv tag, bit 1 = output tag, bit 2 = last tag.
  // Entry 0 is the newest, entry PIPE_LAT-1 is the tail seen by the outputs.
  logic [2:0]  pipe_q [PIPE_LAT];
  logic [2:0]  pipe_d [PIPE_LAT];

  logic        accept;
  logic        last_px;
  logic [2:0]  new_flags;
  logic [2:0]  tail;

  assign in_ready  = (state_q == RUN);
  assign accept    = in_valid & in_ready;
  assign ub_clk_en = accept | (state_q == DRAIN);
  assign busy      = (state_q == RUN) | (state_q == DRAIN);
  assign done      = (state_q == DONE);

  assign last_px   = (x_q == X_MAX) && (y_q == Y_MAX);

  // Drain bubbles (enable high without an accept) push all-zero flags.
  assign new_flags = accept ? {last_px,
                               (x_q >= 16'd4) && (y_q >= 16'd4),
                               (x_q >= 16'd2) && (y_q >= 16'd2)}
                            : 3'b000;

  assign tail       = pipe_q[PIPE_LAT-1];
  assign conv_valid = ub_clk_en & tail[0];
  assign out_valid  = ub_clk_en & tail[1];
  // A last tag is only meaningful on a real output pixel.
  assign out_last   = ub_clk_en & tail[2] & tail[1];

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    drain_cnt_d = drain_cnt_q;
    pipe_d      = pipe_q;

    // The flag pipe moves in lockstep with the line buffers.
    if (ub_clk_en) begin
      pipe_d[0] = new_flags;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
    end

    if (accept) begin
      if (x_q == X_MAX) begin
        x_d = 16'd0;
        y_d = y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          x_d     = 16'd0;
          y_d     = 16'd0;
        end
      end
      RUN: begin
        if (accept && last_px) begin
          state_d     = DRAIN;
          drain_cnt_d = 4'd0;
        end
      end
      DRAIN: begin
        if (drain_cnt_q == DRAIN_MAX) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      drain_cnt_q <= 4'd0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= 3'b000;
      end
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      drain_cnt_q <= drain_cnt_d;
      for (int i = 0; i < PIPE_LAT; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cascade_lake_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cascade_lake_ctrl
//
// Drives a 6x6 frame into two controller instances (PIPE_LAT=1 and
// PIPE_LAT=3) sharing the same stimulus. A behavioural model schedules each
// accepted pixel's tags onto the enable cycle PIPE_LAT enables later and
// predicts every output every cycle; literal cycle numbers and pulse counts
// pin the model down.
// ---------------------------------------------------------------------------
module tb_cascade_lake_ctrl;

  localparam int W = 6;
  localparam int H = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic inValid = 1'b0;

  logic rdyA, enA, convA, outA, lastA, busyA, doneA;
  logic rdyB, enB, convB, outB, lastB, busyB, doneB;

  int checks = 0;
  int failures = 0;

  cascade_lake_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(1)) dutA (
    .clk(clk), .reset(reset), .start(start), .in_valid(inValid),
    .in_ready(rdyA), .ub_clk_en(enA), .conv_valid(convA), .out_valid(outA),
    .out_last(lastA), .busy(busyA), .done(doneA)
  );

  cascade_lake_ctrl #(.IMG_W(W), .IMG_H(H), .PIPE_LAT(3)) dutB (
    .clk(clk), .reset(reset), .start(start), .in_valid(inValid),
    .in_ready(rdyB), .ub_clk_en(enB), .conv_valid(convB), .out_valid(outB),
    .out_last(lastB), .busy(busyB), .done(doneB)
  );

  always #5 clk = ~clk;

  // Model state, one slot per instance.
  // mode: 0 idle, 1 run, 2 drain, 3 done
  int mode [2];
  int drainLeft [2];
  int pixN [2];
  int enIdx [2];
  int frCyc [2];
  int frameNo [2];
  int cntC [2];
  int cntO [2];
  int cntL [2];
  int firstOut [2];
  int lastCyc [2];
  int doneCyc [2];
  int doneTotal [2];
  bit [2:0] tagAt [2][4096];

  string outName [7] = '{"in_ready", "ub_clk_en", "conv_valid", "out_valid",
                         "out_last", "busy", "done"};

  task automatic checkOutput(input string nm, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0d exp=%0d t=%0t", nm, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit s, input bit v);
    start = s;
    inValid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset(input int k);
    mode[k] = 0;
    drainLeft[k] = 0;
    pixN[k] = 0;
    enIdx[k] = 0;
    cntC[k] = 0;
    cntO[k] = 0;
    cntL[k] = 0;
    for (int i = 0; i < 4096; i++) tagAt[k][i] = 3'b000;
  endtask

  task automatic runModel(input int k, input logic [6:0] act);
    int lat;
    int cur;
    int px;
    int py;
    bit expReady;
    bit expAcc;
    bit expEn;
    bit [2:0] tg;
    logic [6:0] expv;
    lat = (k == 0) ? 1 : 3;
    frCyc[k]++;
    if (!reset) begin
      modelReset(k);
      expv = 7'b0;
    end else begin
      expReady = (mode[k] == 1);
      expAcc = inValid && expReady;
      expEn = expAcc || (mode[k] == 2);
      cur = enIdx[k] + 1;
      tg = expEn ? tagAt[k][cur % 4096] : 3'b000;
      expv = {expReady, expEn, tg[0], tg[1], tg[2] & tg[1],
              (mode[k] == 1) || (mode[k] == 2), mode[k] == 3};
    end

    for (int b = 6; b >= 0; b--) begin
      checkOutput($sformatf("L%0d.%s", lat, outName[6-b]), int'(act[b]), int'(expv[b]));
    end

    if (reset) begin
      if (act[4] === 1'b1) cntC[k]++;
      if (act[3] === 1'b1) begin
        cntO[k]++;
        if (frameNo[k] == 1 && firstOut[k] < 0) firstOut[k] = frCyc[k];
      end
      if (act[2] === 1'b1) begin
        cntL[k]++;
        if (frameNo[k] == 1) lastCyc[k] = frCyc[k];
      end
      if (act[0] === 1'b1) begin
        doneTotal[k]++;
        if (frameNo[k] == 1) doneCyc[k] = frCyc[k];
      end
      if (mode[k] == 3) begin
        checkOutput($sformatf("L%0d.conv_count", lat), cntC[k], 16);
        checkOutput($sformatf("L%0d.out_count", lat), cntO[k], 4);
        checkOutput($sformatf("L%0d.last_count", lat), cntL[k], 1);
      end

      // Advance the model to the state after this clock edge.
      if (expEn) begin
        tagAt[k][cur % 4096] = 3'b000;
        if (expAcc) begin
          px = pixN[k] % W;
          py = pixN[k] / W;
          tagAt[k][(cur + lat) % 4096] = {(px == W-1) && (py == H-1),
                                          (px >= 4) && (py >= 4),
                                          (px >= 2) && (py >= 2)};
          pixN[k]++;
        end
        enIdx[k]++;
      end
      case (mode[k])
        0: if (start) begin
          mode[k] = 1;
          pixN[k] = 0;
          frameNo[k]++;
          frCyc[k] = 0;
          cntC[k] = 0;
          cntO[k] = 0;
          cntL[k] = 0;
        end
        1: if (pixN[k] == W*H) begin
          mode[k] = 2;
          drainLeft[k] = lat;
        end
        2: begin
          drainLeft[k]--;
          if (drainLeft[k] == 0) mode[k] = 3;
        end
        default: mode[k] = 0;
      endcase
    end
  endtask

  // Outputs are compared on the falling edge, midway between input changes.
  always @(negedge clk) begin
    runModel(0, {rdyA, enA, convA, outA, lastA, busyA, doneA});
    runModel(1, {rdyB, enB, convB, outB, lastB, busyB, doneB});
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      modelReset(k);
      frCyc[k] = 0;
      frameNo[k] = 0;
      firstOut[k] = -1;
      lastCyc[k] = -1;
      doneCyc[k] = -1;
      doneTotal[k] = 0;
    end
    #1;
    reset = 1'b0;

    // Held in reset with start and in_valid asserted: everything stays 0.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0);

    // Streaming frame, in_valid held high.
    applyStimulus(1'b1, 1'b1);
    for (int i = 1; i <= 44; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("L1.first_out_cycle", firstOut[0], 30);
    checkOutput("L1.last_cycle", lastCyc[0], 37);
    checkOutput("L1.done_cycle", doneCyc[0], 38);
    checkOutput("L3.first_out_cycle", firstOut[1], 32);
    checkOutput("L3.last_cycle", lastCyc[1], 39);
    checkOutput("L3.done_cycle", doneCyc[1], 40);

    // Bubbles: in_valid alternates, with a stray start mid-run.
    applyStimulus(1'b1, 1'b0);
    for (int i = 1; i <= 95; i++) applyStimulus(i == 20, (i % 2) == 1);

    // Stray starts during RUN, DRAIN and DONE are ignored.
    applyStimulus(1'b1, 1'b1);
    for (int i = 1; i <= 45; i++) applyStimulus((i == 5) || (i == 37) || (i == 38), 1'b1);

    // Abort after 20 accepts, then a clean frame.
    applyStimulus(1'b1, 1'b1);
    for (int i = 1; i <= 20; i++) applyStimulus(1'b0, 1'b1);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1);
    for (int i = 1; i <= 45; i++) applyStimulus(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

    checkOutput("L1.frames_done", doneTotal[0], 4);
    checkOutput("L3.frames_done", doneTotal[1], 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cascade_lake_ctrl.md
# cascade_lake_ctrl

Stream scheduler for the two-stage cascaded 3x3 stencil pipeline: input register -> buf1 line buffer -> conv -> buf2 line buffer -> output. It accepts one input pixel per cycle through a valid/ready handshake, drives the shared clock enable of both unified buffers, and tags which datapath results are real. `conv_valid` marks stage-1 results and `out_valid`/`out_last` mark final results. After the last pixel it drains the pipeline and pulses `done`.

## Interface
- IMG_W, 64: frame width in pixels; legal range 5..65535.
- IMG_H, 64: frame height in pixels; legal range 5..65535.
- PIPE_LAT, 1: number of clock-enabled advances from accepting a pixel to its result appearing at the cu_output combinational output; legal range 1..8.

- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low; drives `rst_n` of both unified buffers.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- in_valid  in  1  an input pixel is present on the datapath input.
- in_ready  out  1  the controller accepts the pixel this cycle.
- ub_clk_en  out  1  clock enable for buf1, buf2 and the input register.
- conv_valid  out  1  the conv result for an accepted pixel is valid this cycle.
- out_valid  out  1  the final output pixel is valid this cycle.
- out_last  out  1  qualifies the last `out_valid` of the frame.
- busy  out  1  high in RUN or DRAIN.
- done  out  1  one-cycle pulse at the end of the frame.

## Operation
- FSM states are IDLE, RUN, DRAIN and DONE.
  - IDLE -> RUN on `start`.
  - RUN -> DRAIN on acceptance of pixel (IMG_W-1, IMG_H-1).
  - DRAIN -> DONE after PIPE_LAT drain cycles.
  - DONE -> IDLE unconditionally after 1 cycle.
- Accept means `in_valid & in_ready`. `in_ready` = (state==RUN).
- `ub_clk_en` = accept | (state==DRAIN). When `in_valid` is low in RUN, the enable drops, so the buffers hold and no flags move.
- Coordinate counters x and y are 16 bits each and increment only on accept.
  - x wraps from IMG_W-1 to 0 and increments y at the wrap.
  - Both counters clear on entry to RUN.
- Per accepted pixel, the controller computes three flags:
  - c = (x>=2 && y>=2)
  - o = (x>=4 && y>=4)
  - l = (x==IMG_W-1 && y==IMG_H-1)
- Drain bubbles carry all-zero flags.
- The flags enter a PIPE_LAT-deep shift pipe. The pipe shifts only when `ub_clk_en` is high.
- `conv_valid` = ub_clk_en & tail.c; `out_valid` = ub_clk_en & tail.o; `out_last` = ub_clk_en & tail.l & tail.o. Each tagged pixel therefore pulses exactly once.
- Per frame, the counts are:
  - `conv_valid` pulses: (IMG_W-2)*(IMG_H-2).
  - `out_valid` pulses: (IMG_W-4)*(IMG_H-4).
  - `out_last` pulses: exactly one, coincident with the final `out_valid`.
- `start` is ignored outside IDLE; it does not restart or queue.
- `done` is high exactly during the DONE cycle.

## Timing
- While `reset` is low:
  - state is IDLE.
  - counters and the flag pipe are zero.
  - `in_ready`, `ub_clk_en`, `conv_valid`, `out_valid`, `out_last`, `busy` and `done` are all 0.
- Reset release is taken synchronously to clk.
- Reset asserted mid-frame aborts immediately with no `done` pulse. The buffers are reset through the same pin.
- `start` in cycle t puts the FSM in RUN at t+1, so `in_ready` is first high at t+1.
- The result for pixel n, accepted at a cycle, is tagged on the PIPE_LAT-th subsequent `ub_clk_en` cycle. With continuous input and PIPE_LAT=1 this is the next cycle.
- DRAIN lasts exactly PIPE_LAT cycles with `ub_clk_en`=1 and `in_ready`=0. The last `out_valid`/`out_last` occurs in the final DRAIN cycle.
- `busy` = RUN|DRAIN; it is combinational from state.
- All other outputs are combinational from registered state, pipe contents and `in_valid`. There is no path from `start` to any output in the same cycle.

## Test plan
- **Reset values:** hold `reset` low with `start`=1 and `in_valid`=1 -> all outputs 0. Release and stay idle 10 cycles with `start`=0 -> outputs remain 0.
- **Streaming frame:** IMG_W=IMG_H=6, PIPE_LAT=1, `start` at cycle 0, `in_valid` held high -> 36 accepts on cycles 1..36, 16 `conv_valid` pulses, 4 `out_valid` pulses. The first `out_valid` is at cycle 30 (pixel (4,4) accepted at cycle 29). `out_last` is at cycle 37, the only DRAIN cycle. `done` is at cycle 38, then IDLE.
- **Bubbles:** same frame with `in_valid` toggling 1,0 -> `ub_clk_en` low on every 0 cycle and no tag pulses then. Counts stay 36/16/4/1.
- **PIPE_LAT=3:** continuous 6x6 frame -> DRAIN lasts 3 cycles and `out_last` is in the third. Every tag is delayed 3 enabled cycles from its accept.
- **Ignored start:** pulse `start` during RUN and during DRAIN -> no counter clear and a single `done` per frame.
- **Abort:** assert `reset` after 20 accepts -> outputs 0 immediately. A new `start` then runs a full frame with correct counts.
